// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid buffer: the occupancy state
// encoding and the default payload width.
package pipe_pkg;

  localparam int PIPE_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/skid_data_reg.sv
// One payload register: async reset to zero, synchronous clear, and a load
// enable. The clear has priority over the load.
module skid_data_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer: a main register feeding out_data plus a skid register
// that absorbs one word when downstream stalls. Handshake outputs come from state flops only.
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  state_t           state_q;
  state_t           state_d;
  logic             main_load;
  logic             skid_load;
  logic             xfer_in;
  logic             xfer_out;
  logic [WIDTH-1:0] main_din;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    count     = 2'd0;
    case (state_q)
      EMPTY: begin in_ready = 1'b1; out_valid = 1'b0; count = 2'd0; end
      BUSY:  begin in_ready = 1'b1; out_valid = 1'b1; count = 2'd1; end
      FULL:  begin in_ready = 1'b0; out_valid = 1'b1; count = 2'd2; end
      default: begin in_ready = 1'b0; out_valid = 1'b0; count = 2'd0; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_din  = in_data;
    xfer_in   = in_valid & in_ready;
    xfer_out  = out_valid & out_ready;
    case (state_q)
      EMPTY: begin
        if (xfer_in) begin
          main_load = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (xfer_in && xfer_out) begin
          main_load = 1'b1;
        end else if (xfer_in) begin
          skid_load = 1'b1;
          state_d   = FULL;
        end else if (xfer_out) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Upstream is stalled here, so only the skid word can refill main.
        if (out_ready) begin
          main_load = 1'b1;
          main_din  = skid_q;
          state_d   = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d   = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  skid_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .load  (main_load),
    .d     (main_din),
    .q     (main_q)
  );

  skid_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: directed vector table, reset
// sequences, and a randomized run against a queue reference model.
module tb_pipe_skid_buffer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_q[$];

  typedef struct {
    logic        flush;
    logic        iv;
    logic [31:0] din;
    logic        ordy;
    int          cnt;
    logic        ov;
    logic        ir;
    logic [31:0] od;
  } vec_t;

  vec_t tbl[16];

  pipe_skid_buffer #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] d,
                              input logic ordy, input int cnt, input logic ov,
                              input logic ir, input logic [31:0] od);
    vec_t v;
    v.flush = fl; v.iv = iv; v.din = d; v.ordy = ordy;
    v.cnt = cnt; v.ov = ov; v.ir = ir; v.od = od;
    return v;
  endfunction

  // Reference model: queue of at most two words, updated from handshake rules.
  task automatic model_step(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    int sz;
    sz = model_q.size();
    if (fl) begin
      model_q.delete();
    end else begin
      if (ordy && sz > 0) void'(model_q.pop_front());
      if (iv && sz < 2) model_q.push_back(d);
    end
  endtask

  initial begin
    logic        fl, iv, ordy, just_flushed;
    logic [31:0] d;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {30'd0, count}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    $display("reset: in_ready=%0b out_valid=%0b count=%0d out_data=%h", in_ready, out_valid, count, out_data);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;

    tbl[0]  = mk(0, 1, 32'h1, 1, 1, 1, 1, 32'h1);
    tbl[1]  = mk(0, 1, 32'h2, 1, 1, 1, 1, 32'h2);
    tbl[2]  = mk(0, 1, 32'h3, 1, 1, 1, 1, 32'h3);
    tbl[3]  = mk(0, 0, 32'h0, 1, 0, 0, 1, 32'h3);
    tbl[4]  = mk(0, 1, 32'hA, 0, 1, 1, 1, 32'hA);
    tbl[5]  = mk(0, 1, 32'hB, 0, 2, 1, 0, 32'hA);
    tbl[6]  = mk(0, 1, 32'hC, 0, 2, 1, 0, 32'hA);
    tbl[7]  = mk(0, 1, 32'hC, 0, 2, 1, 0, 32'hA);
    tbl[8]  = mk(0, 1, 32'hC, 0, 2, 1, 0, 32'hA);
    tbl[9]  = mk(0, 1, 32'hC, 1, 1, 1, 1, 32'hB);
    tbl[10] = mk(0, 1, 32'hC, 1, 1, 1, 1, 32'hC);
    tbl[11] = mk(0, 0, 32'h0, 1, 0, 0, 1, 32'hC);
    tbl[12] = mk(0, 1, 32'h5, 0, 1, 1, 1, 32'h5);
    tbl[13] = mk(0, 1, 32'h6, 0, 2, 1, 0, 32'h5);
    tbl[14] = mk(1, 1, 32'h9, 1, 0, 0, 1, 32'h0);
    tbl[15] = mk(0, 0, 32'h0, 1, 0, 0, 1, 32'h0);

    for (int i = 0; i < 16; i++) begin
      flush = tbl[i].flush; in_valid = tbl[i].iv; in_data = tbl[i].din; out_ready = tbl[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), {30'd0, count}, tbl[i].cnt);
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ov});
      check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].ir});
      check($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
      $display("vec%0d: fl=%0b iv=%0b din=%h ordy=%0b -> count=%0d ov=%0b ir=%0b od=%h",
               i, tbl[i].flush, tbl[i].iv, tbl[i].din, tbl[i].ordy, count, out_valid, in_ready, out_data);
      @(negedge clk);
    end

    // Reset asserted between edges while BUSY holding 7.
    flush = 1'b0; in_valid = 1'b1; in_data = 32'h7; out_ready = 1'b0;
    @(posedge clk); #1;
    check("busy7_out_data", out_data, 32'h7);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_count", {30'd0, count}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_data", out_data, 32'd0);
    $display("mid-cycle reset: count=%0d ov=%0b ir=%0b od=%h", count, out_valid, in_ready, out_data);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b1; in_data = 32'h8;
    @(posedge clk); #1;
    check("post_rst_out_data", out_data, 32'h8);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_count", {30'd0, count}, 32'd1);
    $display("after reset send 8: count=%0d ov=%0b od=%h", count, out_valid, out_data);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    flush = 1'b0;
    model_q.delete();

    // Randomized traffic against the queue model.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      fl   = ($urandom_range(0, 63) == 0);
      iv   = $urandom_range(0, 1);
      ordy = $urandom_range(0, 1);
      d    = $urandom;
      flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
      @(posedge clk);
      model_step(fl, iv, d, ordy);
      just_flushed = fl;
      #1;
      check("rnd_count", {30'd0, count}, model_q.size());
      check("rnd_out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
      check("rnd_in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
      if (model_q.size() > 0) check("rnd_out_data", out_data, model_q[0]);
      else if (just_flushed) check("rnd_flush_data", out_data, 32'd0);
      if (cyc % 1000 == 0)
        $display("rnd cyc %0d: fl=%0b iv=%0b ordy=%0b count=%0d od=%h", cyc, fl, iv, ordy, count, out_data);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
